// File: rtl/cbus_pkg.sv
// Shared cache-bus types: request/response bundles and arbiter states.
package cbus_pkg;

  typedef logic [3:0] cbus_len_t;
  typedef logic [2:0] cbus_size_t;

  typedef struct packed {
    logic       valid;
    logic       is_write;
    cbus_size_t size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cbus_arbiter.sv
// Fetch/data arbiter for the shared cache bus.
// Data wins by default; fetch is forced in after STARVE_LIMIT losses.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireq,
  output cbus_resp_t iresp,
  input  cbus_req_t  dreq,
  output cbus_resp_t dresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             gnt_d, gnt_i;
  logic             done;

  always_comb begin
    gnt_d = dreq.valid &&
            (!ireq.valid || starve_cnt_q < LIMIT);
    gnt_i = ireq.valid && !gnt_d;
  end

  assign done = oresp.ready && oresp.last;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    oreq         = '0;
    iresp        = '0;
    dresp        = '0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt_d: begin
            state_d = BUSY_D;
            if (!ireq.valid)
              starve_cnt_d = '0;
            else if (starve_cnt_q != LIMIT)
              starve_cnt_d = starve_cnt_q + 1'b1;
          end
          gnt_i: begin
            state_d      = BUSY_I;
            starve_cnt_d = '0;
          end
          default: ;
        endcase
      end
      BUSY_I: begin
        oreq  = ireq;
        iresp = oresp;
        if (done) state_d = IDLE;
      end
      BUSY_D: begin
        oreq  = dreq;
        dresp = oresp;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter with a grant-order scoreboard.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
  } exp_t;

  logic       clk = 0;
  logic       reset;
  cbus_req_t  ireq, dreq, oreq;
  cbus_resp_t iresp, dresp, oresp;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  cbus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .oreq  (oreq),
    .oresp (oresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cbus_req_t mk(input logic [31:0] a,
                                   input cbus_len_t l);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.size     = 3'd2;
    r.addr     = a;
    r.strobe   = 4'hf;
    r.data     = a ^ 32'h5a5a_5a5a;
    r.len      = l;
    return r;
  endfunction

  // Completion-beat monitor: owner and address must match the queue head.
  always @(negedge clk) begin
    if (!reset && oreq.valid && oresp.ready && oresp.last) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 96'(oreq.addr), 96'hffff_ffff_ffff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_addr", 96'(oreq.addr), 96'(e.addr));
        chk("sb_owner", 96'({iresp.ready, dresp.ready}),
            96'(e.is_d ? 2'b01 : 2'b10));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    ireq  = '0;
    dreq  = '0;
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'hd00d_cafe};
    tick();
    tick();
    reset = 0;
    #1;
    chk("rst_oreq", 96'(oreq), 96'(0));
    chk("rst_iresp", 96'(iresp), 96'(0));
    chk("rst_dresp", 96'(dresp), 96'(0));
    chk("rst_state", 96'(dut.state_q), 96'(IDLE));
    chk("rst_cnt", 96'(dut.starve_cnt_q), 96'(0));

    // 1: fetch only, zero-wait
    ireq = mk(32'hbfc0_0000, 4'd0);
    sb.push_back('{1'b0, 32'hbfc0_0000});
    tick();
    chk("t1_addr", 96'(oreq.addr), 96'hbfc0_0000);
    chk("t1_iready", 96'(iresp.ready), 96'(1));
    chk("t1_idata", 96'(iresp.data), 96'hd00d_cafe);
    chk("t1_dready", 96'(dresp.ready), 96'(0));
    tick();
    chk("t1_idle", 96'(dut.state_q), 96'(IDLE));
    chk("t1_bubble", 96'(oreq.valid), 96'(0));
    ireq = '0;

    // 2: both valid, data first, fetch after one bubble
    ireq = mk(32'h0000_1000, 4'd0);
    dreq = mk(32'h0000_2000, 4'd0);
    sb.push_back('{1'b1, 32'h0000_2000});
    sb.push_back('{1'b0, 32'h0000_1000});
    tick();
    chk("t2_d_own", 96'(dresp.ready), 96'(1));
    chk("t2_i_wait", 96'(iresp.ready), 96'(0));
    tick();
    chk("t2_idle", 96'(dut.state_q), 96'(IDLE));
    dreq = '0;
    tick();
    chk("t2_i_own", 96'(iresp.ready), 96'(1));
    chk("t2_i_addr", 96'(oreq.addr), 96'h0000_1000);
    tick();
    ireq = '0;

    // 3: 4-beat data burst, fetch arrives mid-burst
    oresp.last = 1'b0;
    dreq = mk(32'h0000_3000, 4'd3);
    sb.push_back('{1'b1, 32'h0000_3000});
    tick();
    ireq = mk(32'h0000_4000, 4'd0);
    sb.push_back('{1'b0, 32'h0000_4000});
    for (int b = 0; b < 4; b++) begin
      oresp.last = (b == 3);
      #1;
      chk("t3_dbeat", 96'(dresp.ready), 96'(1));
      chk("t3_ihold", 96'(iresp.ready), 96'(0));
      chk("t3_addr", 96'(oreq.addr), 96'h0000_3000);
      if (b < 3) tick();
    end
    tick();
    dreq = '0;
    chk("t3_bubble", 96'(oreq.valid), 96'(0));
    tick();
    chk("t3_i_own", 96'(iresp.ready), 96'(1));
    tick();
    ireq = '0;

    // 4: both continuously valid, starvation rotation
    ireq = mk(32'h0000_5000, 4'd0);
    dreq = mk(32'h0000_6000, 4'd0);
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) sb.push_back('{1'b0, 32'h0000_5000});
      else            sb.push_back('{1'b1, 32'h0000_6000});
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_cnt", 96'(dut.starve_cnt_q),
          96'((k % 5 == 4) ? 0 : (k % 5) + 1));
      tick();
    end
    ireq = '0;
    dreq = '0;

    // 5: data owner stalled, fetch must not preempt
    oresp.ready = 1'b0;
    dreq = mk(32'h0000_7000, 4'd0);
    ireq = mk(32'h0000_8000, 4'd0);
    sb.push_back('{1'b1, 32'h0000_7000});
    sb.push_back('{1'b0, 32'h0000_8000});
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_oreq", 96'(oreq), 96'(dreq));
      chk("t5_iresp", 96'(iresp), 96'(0));
    end
    oresp.ready = 1'b1;
    #1;
    chk("t5_done", 96'(dresp.ready), 96'(1));
    tick();
    dreq = '0;
    tick();
    chk("t5_i_own", 96'(iresp.ready), 96'(1));
    tick();
    ireq = '0;

    // 6: reset mid-burst abandons the transfer
    oresp.last = 1'b0;
    ireq = mk(32'h0000_9000, 4'd3);
    tick();
    tick();
    tick();
    chk("t6_beat2", 96'(iresp.ready), 96'(1));
    reset = 1;
    ireq  = '0;
    tick();
    reset = 0;
    oresp.last = 1'b1;
    #1;
    chk("t6_valid", 96'(oreq.valid), 96'(0));
    chk("t6_iresp", 96'(iresp), 96'(0));
    chk("t6_state", 96'(dut.state_q), 96'(IDLE));
    chk("t6_cnt", 96'(dut.starve_cnt_q), 96'(0));
    dreq = mk(32'h0000_a000, 4'd0);
    sb.push_back('{1'b1, 32'h0000_a000});
    tick();
    chk("t6_d_own", 96'(dresp.ready), 96'(1));
    chk("t6_d_addr", 96'(oreq.addr), 96'h0000_a000);
    tick();
    dreq = '0;
    tick();
    chk("sb_drained", 96'(sb.size()), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
